dtmf_tone_detector: RTL and testbench
=====================================

// Module: dtmf_tone_detector
// PURPOSE
//  Receive-side companion to the DTMF tone generators. Measures the period of an
//  incoming single-tone square wave, sampled on the 1 MHz system clock, and
//  classifies it as one of the 8 DTMF frequencies. After CONFIRM consecutive
//  matching periods it reports the tone index. Sits between the tone input pin
//  (or a loopback from the generators) and the keypad-decode logic.
// PARAMETERS
//  TOL      20    max |measured - nominal| period error, in clocks (must be < 32)
//  CONFIRM  4     consecutive matching periods required to assert tone_valid (1..15)
//  TIMEOUT  2047  clocks with no rising edge before lock is dropped
//  Nominal periods in clocks (fixed localparams), idx 0..7 = 697,770,852,941,
//  1209,1336,1477,1633 Hz -> 1435,1299,1174,1063,827,749,677,612
// PORTS
//  clk_1m_in     in   1   1 MHz system clock
//  reset_b       in   1   synchronous active-low reset, sampled on posedge clk_1m_in
//  tone_in       in   1   asynchronous square-wave tone input
//  tone_valid    out  1   registered; a DTMF frequency is locked
//  tone_idx      out  3   registered; index of the locked frequency, valid while tone_valid
//  period_out    out  12  last measured period, in clocks
//  period_strb   out  1   one-cycle pulse when period_out updates
// BEHAVIOUR
//  - reset_b=0 at posedge: all outputs 0, counters 0, synchroniser flops 0, state IDLE.
//  - Sync: 2-FF synchroniser plus an edge flop; rise = s2 & ~s3.
//    Pin to rise pulse: 3 clocks.
//  - Period counter cnt (12 b):
//    - on rise: cnt<=1; otherwise cnt<=cnt+1, saturating at 4095.
//    - Measured period = cnt value in the rise cycle.
//  - States:
//    - IDLE: ignore cnt; first rise -> MEASURE. No period is reported for the first edge.
//    - MEASURE/LOCKED, on rise:
//      - period_out<=cnt; period_strb=1 on the next clock (latency 1).
//      - Match: idx i matches when |cnt - P_i| <= TOL. Windows never overlap, so at most one idx matches.
//      - Match with i == cand: match_cnt++, saturating at CONFIRM.
//      - Match with i != cand: cand<=i, match_cnt<=1.
//      - No match: match_cnt<=0.
//    - Enter LOCKED when match_cnt reaches CONFIRM. In the same clock edge: tone_valid<=1, tone_idx<=cand.
//    - In LOCKED, on a no-match period or a different idx: tone_valid<=0 at the next edge, return to MEASURE.
//    - Timeout: cnt reaches TIMEOUT with no rise (any state except IDLE) -> IDLE, tone_valid<=0, match_cnt<=0.
//  - Simultaneous rise and timeout in the same cycle: rise wins (period measured = TIMEOUT, then no match).
//  - tone_idx holds its last value when tone_valid drops; consumers must qualify it with tone_valid.
//  - Mid-operation reset: immediate return to reset values; lock must be re-acquired from IDLE.
// CONFIGURATION
//  DTMF_GLITCH_FILTER_EN:
//    - Defined: s2 must hold the same level for 3 consecutive clocks before the
//      filtered level changes. Rise is taken from the filtered level. Pin-to-rise latency is 5 clocks.
//      Pulses of 1-2 clocks are ignored.
//    - Undefined: no filter; any s2 transition counts (latency 3).
//    - Period measurements are identical in both cases for clean inputs.
// TESTING
//  1. Square wave, period 612 (306 high/306 low) -> period_out=612 each strobe;
//     tone_valid=1, tone_idx=7 one clock after the CONFIRM-th measured period (5th rise).
//  2. Period 1435 -> idx 0. Period 1435+20 -> still idx 0. Period 1435+21 -> no match, tone_valid stays 0.
//  3. Locked on 827 (idx 4), input switches to 749 -> tone_valid drops after the first 749 period,
//     then re-asserts with tone_idx=5 after 4 periods of 749.
//  4. Locked, tone_in held low -> tone_valid=0 exactly when cnt hits 2047; state IDLE;
//     next single rise produces no strobe.
//  5. Locked, reset_b=0 for 1 clock mid-period -> all outputs 0 at the next edge;
//     relock needs 1+CONFIRM rises.
//  6. With DTMF_GLITCH_FILTER_EN: a 2-clock high pulse injected mid-low-phase of a 612 tone
//     -> ignored, lock kept. Without the macro: a short-period mismatch drops tone_valid.

Source files
------------

// File: rtl/dtmf_tone_detector.sv
// rtl/dtmf_tone_detector.sv - DTMF tone detector: period measurement, window match, lock/confirm FSM.
// Optional 3-clock input glitch filter enabled by defining DTMF_GLITCH_FILTER_EN.
module dtmf_tone_detector #(
  parameter int TOL     = 20,
  parameter int CONFIRM = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic        clk_1m_in,
  input  logic        reset_b,
  input  logic        tone_in,
  output logic        tone_valid,
  output logic [2:0]  tone_idx,
  output logic [11:0] period_out,
  output logic        period_strb
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  localparam logic [12:0] TOL_C     = 13'(TOL);
  localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM);
  localparam logic [11:0] TIMEOUT_C = 12'(TIMEOUT);

  function automatic logic [12:0] nominal(input logic [2:0] i);
    case (i)
      3'd0:    nominal = 13'd1435;
      3'd1:    nominal = 13'd1299;
      3'd2:    nominal = 13'd1174;
      3'd3:    nominal = 13'd1063;
      3'd4:    nominal = 13'd827;
      3'd5:    nominal = 13'd749;
      3'd6:    nominal = 13'd677;
      default: nominal = 13'd612;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        s1_q, s2_q, edge_q;
  logic        rise;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  cand_q, cand_d;
  logic [3:0]  mc_q, mc_d;
  logic        valid_q, valid_d;
  logic [2:0]  idx_q, idx_d;
  logic [11:0] period_q, period_d;
  logic        strb_q, strb_d;
  logic        match;
  logic [2:0]  match_idx;

`ifdef DTMF_GLITCH_FILTER_EN
  // edge_q is the filtered level; it follows s2 only after three equal samples.
  logic h1_q, h2_q;
  logic level_d;

  always_comb begin
    level_d = edge_q;
    if ((s2_q == h1_q) && (h1_q == h2_q)) level_d = s2_q;
  end

  assign rise = level_d & ~edge_q;

  always_ff @(posedge clk_1m_in) begin
    if (!reset_b) begin
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      h1_q <= s2_q;
      h2_q <= h1_q;
    end
  end
`else
  logic level_d;
  assign level_d = s2_q;
  assign rise    = s2_q & ~edge_q;
`endif

  always_comb begin
    match     = 1'b0;
    match_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (({1'b0, cnt_q} + TOL_C >= nominal(3'(i))) && ({1'b0, cnt_q} <= nominal(3'(i)) + TOL_C)) begin
        match     = 1'b1;
        match_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? 12'd1 : ((cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1);
    cand_d   = cand_q;
    mc_d     = mc_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    period_d = period_q;
    strb_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      default: begin
        if (rise) begin
          period_d = cnt_q;
          strb_d   = 1'b1;
          if (match && (match_idx == cand_q)) begin
            mc_d = (mc_q >= CONFIRM_C) ? CONFIRM_C : mc_q + 4'd1;
          end else if (match) begin
            cand_d = match_idx;
            mc_d   = 4'd1;
          end else begin
            mc_d = 4'd0;
          end
          if (state_q == LOCKED) begin
            if (!match || (match_idx != cand_q)) begin
              valid_d = 1'b0;
              state_d = MEASURE;
            end
          end else if (match && (mc_d >= CONFIRM_C)) begin
            state_d = LOCKED;
            valid_d = 1'b1;
            idx_d   = cand_d;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          // A rise in the same cycle takes the branch above instead.
          state_d = IDLE;
          valid_d = 1'b0;
          mc_d    = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_1m_in) begin
    if (!reset_b) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      edge_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 12'd0;
      cand_q   <= 3'd0;
      mc_q     <= 4'd0;
      valid_q  <= 1'b0;
      idx_q    <= 3'd0;
      period_q <= 12'd0;
      strb_q   <= 1'b0;
    end else begin
      s1_q     <= tone_in;
      s2_q     <= s1_q;
      edge_q   <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      mc_q     <= mc_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      period_q <= period_d;
      strb_q   <= strb_d;
    end
  end

  assign tone_valid  = valid_q;
  assign tone_idx    = idx_q;
  assign period_out  = period_q;
  assign period_strb = strb_q;

endmodule

// File: tb/tb_dtmf_tone_detector.sv
// tb/tb_dtmf_tone_detector.sv - scoreboard bench for dtmf_tone_detector
module tb_dtmf_tone_detector;

  typedef struct {
    int         period;
    bit         valid;
    logic [2:0] idx;
  } exp_t;

  logic        clk_1m_in = 1'b0;
  logic        reset_b   = 1'b0;
  logic        tone_in   = 1'b0;
  logic        tone_valid;
  logic [2:0]  tone_idx;
  logic [11:0] period_out;
  logic        period_strb;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  int   last_rise_cyc = 0;
  bit   armed = 1'b0;
  exp_t sb[$];

  dtmf_tone_detector dut (
    .clk_1m_in  (clk_1m_in),
    .reset_b    (reset_b),
    .tone_in    (tone_in),
    .tone_valid (tone_valid),
    .tone_idx   (tone_idx),
    .period_out (period_out),
    .period_strb(period_strb)
  );

  always #5 clk_1m_in = ~clk_1m_in;
  always @(posedge clk_1m_in) cyc <= cyc + 1;

  always @(negedge clk_1m_in) begin
    if (period_strb) begin
      exp_t e;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: period_out=%0d, required no strobe", period_out);
      end else begin
        e = sb.pop_front();
        if (period_out !== 12'(e.period)) begin
          errors++;
          $display("FAIL period_out: got %0d, required %0d", period_out, e.period);
        end
        checks++;
        if (tone_valid !== e.valid) begin
          errors++;
          $display("FAIL tone_valid_at_strobe: got %0b, required %0b (period %0d)", tone_valid, e.valid, e.period);
        end
        if (e.valid) begin
          checks++;
          if (tone_idx !== e.idx) begin
            errors++;
            $display("FAIL tone_idx_at_strobe: got %0d, required %0d", tone_idx, e.idx);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_1m_in);
      #2;
    end
  endtask

  task automatic do_rise(input bit ev, input logic [2:0] ei);
    exp_t e;
    if (armed) begin
      e.period = cyc - last_rise_cyc;
      e.valid  = ev;
      e.idx    = ei;
      sb.push_back(e);
    end
    armed         = 1'b1;
    last_rise_cyc = cyc;
    tone_in       = 1'b1;
  endtask

  task automatic drive_wave(input int per, input int n, input int lock_at, input logic [2:0] ei);
    if (!armed) do_rise(1'b0, 3'd0);
    for (int k = 1; k <= n; k++) begin
      tick(per / 2);
      tone_in = 1'b0;
      tick(per - per / 2);
      do_rise((lock_at != 0) && (k >= lock_at), ei);
    end
  endtask

  task automatic apply_reset();
    tone_in = 1'b0;
    tick(10);
    reset_b = 1'b0;
    tick(1);
    @(negedge clk_1m_in);
    reset_b = 1'b1;
    armed   = 1'b0;
    sb.delete();
  endtask

  task automatic check_drained(input string name);
    tick(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d strobes missing, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (tone_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", tone_valid); end
    checks++;
    if (tone_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", tone_idx); end
    checks++;
    if (period_out !== 12'd0) begin errors++; $display("FAIL reset_period: got %0d, required 0", period_out); end
    checks++;
    if (period_strb !== 1'b0) begin errors++; $display("FAIL reset_strb: got %0b, required 0", period_strb); end
  endtask

  task automatic test_lock_612();
    apply_reset();
    drive_wave(612, 6, 4, 3'd7);
    check_drained("lock_612");
  endtask

  task automatic test_tolerance();
    apply_reset();
    drive_wave(1435, 5, 4, 3'd0);
    check_drained("tol_1435");
    apply_reset();
    drive_wave(1455, 5, 4, 3'd0);
    check_drained("tol_1455");
    apply_reset();
    drive_wave(1456, 5, 0, 3'd0);
    check_drained("tol_1456");
    checks++;
    if (tone_valid !== 1'b0) begin errors++; $display("FAIL tol_1456_valid: got %0b, required 0", tone_valid); end
  endtask

  task automatic test_switch();
    apply_reset();
    drive_wave(827, 5, 4, 3'd4);
    drive_wave(749, 5, 4, 3'd5);
    check_drained("switch");
  endtask

  task automatic test_timeout();
    int sc;
    bit found;
    apply_reset();
    drive_wave(612, 5, 4, 3'd7);
    tick(306);
    tone_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_1m_in);
      if (!tone_valid) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_drop: tone_valid still 1 after 3000 clocks, required 0");
    end else if (cyc - last_strobe_cyc != 2047) begin
      errors++;
      $display("FAIL timeout_clocks: dropped %0d clocks after last strobe, required 2047", cyc - last_strobe_cyc);
    end
    checks++;
    if (tone_idx !== 3'd7) begin errors++; $display("FAIL timeout_idx_hold: got %0d, required 7", tone_idx); end
    armed = 1'b0;
    sc = strobe_cnt;
    tick(2);
    do_rise(1'b0, 3'd0);
    tick(20);
    tone_in = 1'b0;
    tick(20);
    checks++;
    if (strobe_cnt != sc) begin errors++; $display("FAIL timeout_first_rise: %0d strobes, required 0", strobe_cnt - sc); end
    check_drained("timeout");
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive_wave(612, 5, 4, 3'd7);
    tick(306);
    tone_in = 1'b0;
    tick(100);
    reset_b = 1'b0;
    tick(1);
    @(negedge clk_1m_in);
    reset_b = 1'b1;
    armed   = 1'b0;
    sb.delete();
    checks++;
    if ({tone_valid, tone_idx, period_out, period_strb} !== 17'd0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%0b idx=%0d period=%0d strb=%0b, required all 0",
               tone_valid, tone_idx, period_out, period_strb);
    end
    tick(50);
    drive_wave(612, 5, 4, 3'd7);
    check_drained("midreset");
  endtask

  task automatic test_glitch();
    apply_reset();
    drive_wave(612, 5, 4, 3'd7);
    tick(306);
    tone_in = 1'b0;
    tick(100);
`ifdef DTMF_GLITCH_FILTER_EN
    tone_in = 1'b1;
    tick(2);
    tone_in = 1'b0;
    tick(204);
    do_rise(1'b1, 3'd7);
    drive_wave(612, 3, 1, 3'd7);
`else
    do_rise(1'b0, 3'd0);
    tick(2);
    tone_in = 1'b0;
    tick(204);
    do_rise(1'b0, 3'd0);
    drive_wave(612, 5, 4, 3'd7);
`endif
    check_drained("glitch");
  endtask

  initial begin
    test_reset();
    test_lock_612();
    test_tolerance();
    test_switch();
    test_timeout();
    test_mid_reset();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
